// File: rtl/ov7670_capture_controller.sv
// OV7670 RGB565 capture: assembles byte pairs into pixels and writes them into a
// row/column addressed frame buffer, all in the camera pixel-clock domain.
module ov7670_capture_controller #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              frame_err
);
    localparam int COL_W = $clog2(H_RES + 2);
    localparam int ROW_W = $clog2(V_RES + 1);
    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_RES);
    localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_RES + 1);
    localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {SYNC, BLANK, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic               vsync_q, href_q, vsync_prev_q, href_prev_q;
    logic [7:0]         data_q;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic               phase_q, phase_d;
    logic [7:0]         hi_q, hi_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_err_q, frame_err_d;
    logic               vs_rise, vs_fall, href_fall;

    assign vs_rise   = vsync_q & ~vsync_prev_q;
    assign vs_fall   = ~vsync_q & vsync_prev_q;
    assign href_fall = href_prev_q & ~href_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SYNC;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            line_base_q  <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            href_q       <= href;
            data_q       <= data;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
            col_q        <= col_d;
            row_q        <= row_d;
            line_base_q  <= line_base_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        line_base_d  = line_base_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (state_q)
            SYNC: begin
                if (vsync_q) state_d = BLANK;
            end
            BLANK: begin
                col_d       = '0;
                row_d       = '0;
                line_base_d = '0;
                phase_d     = 1'b0;
                if (vs_fall) begin
                    state_d     = ACTIVE;
                    frame_err_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (href_q && !vsync_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (col_q < COL_FULL && row_q < ROW_FULL) begin
                            we_d    = 1'b1;
                            wdata_d = {hi_q, data_q};
                            waddr_d = line_base_q + ADDR_W'(col_q);
                        end
                        // col keeps counting past H_RES so over-long lines are flagged
                        if (col_q != COL_SAT) col_d = col_q + COL_W'(1);
                    end
                end
                if (href_fall) begin
                    if (col_q != COL_FULL || row_q >= ROW_FULL) frame_err_d = 1'b1;
                    col_d   = '0;
                    phase_d = 1'b0;
                    if (row_q < ROW_FULL) begin
                        row_d       = row_q + ROW_W'(1);
                        line_base_d = line_base_q + LINE_STEP;
                    end
                end
                // row_d already includes a coincident line end
                if (vs_rise) begin
                    if (row_d != ROW_FULL || href_q) frame_err_d = 1'b1;
                    state_d      = BLANK;
                    frame_done_d = 1'b1;
                    phase_d      = 1'b0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_ov7670_capture_controller.sv
// Randomised bench for ov7670_capture_controller: a frame-level model predicts the
// write list and per-frame error flag; a negedge monitor checks the DUT every cycle.
module tb_ov7670_capture_controller;
    localparam int HR = 20;
    localparam int VR = 12;
    localparam int AW = 8;

    logic           pclk = 1'b0;
    logic           reset_n = 1'b1;
    logic           vsync = 1'b0;
    logic           href = 1'b0;
    logic [7:0]     data = 8'h00;
    logic           we;
    logic [AW-1:0]  wAddr;
    logic [15:0]    wData;
    logic           frame_done;
    logic           frame_err;

    typedef struct {
        int          addr;
        logic [15:0] pix;
    } wr_t;

    wr_t         exp_w[$];
    bit          exp_err[$];
    wr_t         cur;
    int          plan[$];
    int          tests = 0;
    int          failures = 0;
    bit          checking = 1'b0;
    bit          armed = 1'b0;
    bit          m_err = 1'b0;
    int          m_row = 0;
    int          last_addr = 0;
    logic [15:0] last_pix = 16'h0000;

    ov7670_capture_controller #(.H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
        .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .data(data),
        .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        @(posedge pclk);
        #1;
        vsync = v;
        href  = h;
        data  = d;
    endtask

    task automatic pushPixel(input int col, input logic [15:0] pix);
        if (armed && col < HR && m_row < VR) exp_w.push_back('{addr: m_row * HR + col, pix: pix});
    endtask

    task automatic modelLineEnd(input int pixels);
        if (armed) begin
            if (pixels != HR || m_row >= VR) m_err = 1'b1;
            m_row++;
        end
    endtask

    task automatic sendBytes(input int nbytes, input bit pattern);
        logic [7:0] hi;
        logic [7:0] b;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            if (pattern) b = (i % 2 == 0) ? 8'(m_row) : 8'(i / 2);
            else         b = 8'($urandom);
            if (i % 2 == 0) hi = b;
            else            pushPixel(i / 2, {hi, b});
            applyStimulus(1'b0, 1'b1, b);
        end
    endtask

    task automatic sendLine(input int nbytes, input bit pattern, input int gap);
        sendBytes(nbytes, pattern);
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'h00);
        modelLineEnd(nbytes / 2);
    endtask

    task automatic vsyncRise();
        if (armed) exp_err.push_back(m_err || (m_row != VR));
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);
        if (armed) checkOutput("writes_drained", exp_w.size(), 0);
        armed = 1'b1;
        m_row = 0;
        m_err = 1'b0;
    endtask

    task automatic vsyncFall();
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // vsync rises while href is still high: the frame ends in error
    task automatic sendMidVsync(input int nbytes);
        sendBytes(nbytes, 1'b0);
        if (armed) exp_err.push_back(1'b1);
        repeat (3) applyStimulus(1'b1, 1'b1, 8'($urandom));
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
        armed = 1'b1;
        m_row = 0;
        m_err = 1'b0;
    endtask

    task automatic fillPlan(input int n, input int nbytes);
        plan.delete();
        repeat (n) plan.push_back(nbytes);
    endtask

    task automatic runPlan(input bit pattern, input bit mid_end);
        for (int l = 0; l < plan.size(); l++) begin
            if (mid_end && l == plan.size() - 1) begin
                sendMidVsync(plan[l]);
                return;
            end
            sendLine(plan[l], pattern,
                     (l == plan.size() - 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 4)));
        end
        vsyncRise();
    endtask

    task automatic doReset();
        checking = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_we", we, 0);
        checkOutput("reset_wAddr", wAddr, 0);
        checkOutput("reset_wData", wData, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        exp_w.delete();
        exp_err.delete();
        armed = 1'b0;
        m_row = 0;
        m_err = 1'b0;
        last_addr = 0;
        last_pix = 16'h0000;
        vsync = 1'b0;
        href = 1'b0;
        data = 8'h00;
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        checking = 1'b1;
    endtask

    always @(negedge pclk) begin
        if (checking) begin
            if (we) begin
                if (exp_w.size() == 0) begin
                    checkOutput("unexpected_we", 32'(we), 32'd0);
                end else begin
                    cur = exp_w.pop_front();
                    checkOutput("wAddr", wAddr, cur.addr);
                    checkOutput("wData", wData, cur.pix);
                    last_addr = cur.addr;
                    last_pix  = cur.pix;
                end
                checkOutput("wAddr_in_range", 32'(wAddr <= AW'(HR * VR - 1)), 32'd1);
            end else begin
                checkOutput("wAddr_hold", wAddr, last_addr);
                checkOutput("wData_hold", wData, last_pix);
            end
            if (frame_done) begin
                if (exp_err.size() == 0) checkOutput("unexpected_frame_done", 32'(frame_done), 32'd0);
                else                     checkOutput("frame_err_at_done", frame_err, exp_err.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();

        // out of reset mid-frame: nothing may be written before a vsync cycle
        repeat (3) sendLine(2 * HR, 1'b0, 2);
        vsyncRise();
        vsyncFall();

        // single pixel A5,3C on line 0, then the rest of the frame
        applyStimulus(1'b0, 1'b1, 8'hA5);
        pushPixel(0, 16'hA53C);
        applyStimulus(1'b0, 1'b1, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge pclk);
        checkOutput("lat_we_early", we, 0);
        @(negedge pclk);
        checkOutput("lat_we", we, 1);
        checkOutput("lat_wData", wData, 16'hA53C);
        checkOutput("lat_wAddr", wAddr, 0);
        modelLineEnd(1);
        fillPlan(VR - 1, 2 * HR);
        runPlan(1'b0, 1'b0);
        checkOutput("lat_frame_err", frame_err, 1);
        vsyncFall();

        // clean frame with (row<<8|col) pixels
        fillPlan(VR, 2 * HR);
        runPlan(1'b1, 1'b0);
        checkOutput("clean_frame_err", frame_err, 0);
        vsyncFall();

        // long line then short line
        plan.delete();
        plan.push_back(2 * (HR + 10));
        plan.push_back(2 * (HR - 5));
        repeat (VR - 2) plan.push_back(2 * HR);
        runPlan(1'b1, 1'b0);
        checkOutput("ls_err_set", frame_err, 1);
        vsyncFall();
        @(negedge pclk);
        checkOutput("ls_err_cleared", frame_err, 0);

        // odd byte count: stray trailing byte dropped, no error
        plan.delete();
        plan.push_back(2 * HR + 1);
        repeat (VR - 1) plan.push_back(2 * HR);
        runPlan(1'b0, 1'b0);
        checkOutput("odd_frame_err", frame_err, 0);
        vsyncFall();

        // too many lines
        fillPlan(VR + 10, 2 * HR);
        runPlan(1'b0, 1'b0);
        checkOutput("overflow_err", frame_err, 1);
        vsyncFall();

        // randomised frames
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = ($urandom_range(0, 2) == 0) ? VR - 1 + int'($urandom_range(0, 2)) : VR;
            plan.delete();
            for (int l = 0; l < nl; l++)
                plan.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 2 * HR + 6)) : 2 * HR);
            runPlan(1'b0, $urandom_range(0, 3) == 0);
            vsyncFall();
        end

        // reset in the middle of a frame
        repeat (3) sendLine(2 * HR, 1'b0, 3);
        checking = 1'b0;
        repeat (7) applyStimulus(1'b0, 1'b1, 8'($urandom));
        doReset();
        repeat (2) sendLine(2 * HR, 1'b0, 2);
        vsyncRise();
        vsyncFall();
        fillPlan(VR, 2 * HR);
        runPlan(1'b1, 1'b0);
        checkOutput("post_reset_err", frame_err, 0);
        vsyncFall();

        repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("final_writes_empty", exp_w.size(), 0);
        checkOutput("final_done_empty", exp_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
